// File: rtl/isa_pkg.sv
// Shared ISA definitions: field widths, opcode encodings and the sequencer state type.
// The same encodings are decoded by the EX forwarding unit.
package isa_pkg;

  localparam int REGW = 3;
  localparam int OPW  = 6;
  localparam int IMMW = 9;

  // Bits [5:2] hold the major opcode; bits [1:0] hold the condition/function bits.
  localparam logic [OPW-1:0] ADD = 6'b000000;
  localparam logic [OPW-1:0] ADC = 6'b000010;
  localparam logic [OPW-1:0] ADZ = 6'b000001;
  localparam logic [OPW-1:0] ADI = 6'b000100;
  localparam logic [OPW-1:0] NDU = 6'b001000;
  localparam logic [OPW-1:0] NDC = 6'b001010;
  localparam logic [OPW-1:0] NDZ = 6'b001001;
  localparam logic [OPW-1:0] LHI = 6'b001100;
  localparam logic [OPW-1:0] LW  = 6'b010000;
  localparam logic [OPW-1:0] SW  = 6'b010100;
  localparam logic [OPW-1:0] LM  = 6'b011000;
  localparam logic [OPW-1:0] SM  = 6'b011100;
  localparam logic [OPW-1:0] BEQ = 6'b110000;
  localparam logic [OPW-1:0] JAL = 6'b100000;
  localparam logic [OPW-1:0] JLR = 6'b100100;

  localparam logic [3:0] MAJ_LM = 4'b0110;
  localparam logic [3:0] MAJ_SM = 4'b0111;

  typedef enum logic {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } state_e;

  // Multi-register ops are recognised by major opcode alone, whatever the low bits hold.
  function automatic logic isMultiOp(input logic [OPW-1:0] op);
    return (op[5:2] == MAJ_LM) || (op[5:2] == MAJ_SM);
  endfunction

endpackage

// File: rtl/lm_sm_sequencer_if.sv
// Decode-side and register-read-side signals of the LM/SM sequencer stage.
// The slave modport is the sequencer; the master modport is its environment.
interface lm_sm_sequencer_if;
  import isa_pkg::*;

  logic            in_valid;
  logic [OPW-1:0]  in_op;
  logic [REGW-1:0] in_regA;
  logic [REGW-1:0] in_regB;
  logic [REGW-1:0] in_regC;
  logic [IMMW-1:0] in_imm;
  logic            stall_in;
  logic            flush;
  logic            in_ready;

  logic            out_valid;
  logic [OPW-1:0]  out_op;
  logic [REGW-1:0] out_regA;
  logic [REGW-1:0] out_regB;
  logic [REGW-1:0] out_regC;
  logic [IMMW-1:0] out_imm;
  logic [2:0]      out_offset;
  logic            out_first;
  logic            out_last;

  modport slave (
    input  in_valid, in_op, in_regA, in_regB, in_regC, in_imm, stall_in, flush,
    output in_ready, out_valid, out_op, out_regA, out_regB, out_regC, out_imm,
           out_offset, out_first, out_last
  );

  modport master (
    output in_valid, in_op, in_regA, in_regB, in_regC, in_imm, stall_in, flush,
    input  in_ready, out_valid, out_op, out_regA, out_regB, out_regC, out_imm,
           out_offset, out_first, out_last
  );

endinterface

// File: rtl/pri_enc8.sv
// Lowest-set-bit encoder for an 8-bit register mask; anyO flags a non-empty mask.
module pri_enc8 (
  input  logic [7:0] vec_i,
  output logic [2:0] idx_o,
  output logic       any_o
);

  // Scanning from the top down lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx_o = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec_i[i]) idx_o = 3'(i);
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/lm_sm_sequencer.sv
// Decode-to-register-read pipeline register that expands LM/SM into one micro-op
// per set mask bit, holding decode off until the expansion finishes.
module lm_sm_sequencer
  import isa_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  lm_sm_sequencer_if.slave   bus
);

  state_e          state_q,  state_d;
  logic [7:0]      mask_q,   mask_d;
  logic [2:0]      count_q,  count_d;
  logic            valid_q,  valid_d;
  logic [OPW-1:0]  op_q,     op_d;
  logic [REGW-1:0] regA_q,   regA_d;
  logic [REGW-1:0] regB_q,   regB_d;
  logic [REGW-1:0] regC_q,   regC_d;
  logic [IMMW-1:0] imm_q,    imm_d;
  logic [2:0]      offset_q, offset_d;
  logic            first_q,  first_d;
  logic            last_q,   last_d;

  logic [2:0] inIdx, pendIdx;
  logic       inAny, pendAny;
  logic [7:0] inRest, pendRest;
  logic       accept;

  pri_enc8 uInEnc (
    .vec_i (bus.in_imm[7:0]),
    .idx_o (inIdx),
    .any_o (inAny)
  );

  pri_enc8 uPendEnc (
    .vec_i (mask_q),
    .idx_o (pendIdx),
    .any_o (pendAny)
  );

  assign inRest   = bus.in_imm[7:0] & ~(8'b1 << inIdx);
  assign pendRest = mask_q & ~(8'b1 << pendIdx);

  assign bus.in_ready = (state_q == IDLE) && !bus.stall_in;
  assign accept       = bus.in_valid && bus.in_ready;

  // Flush beats stall, stall freezes everything, otherwise advance the expander.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    count_d  = count_q;
    valid_d  = valid_q;
    op_d     = op_q;
    regA_d   = regA_q;
    regB_d   = regB_q;
    regC_d   = regC_q;
    imm_d    = imm_q;
    offset_d = offset_q;
    first_d  = first_q;
    last_d   = last_q;

    if (bus.flush) begin
      valid_d = 1'b0;
      state_d = IDLE;
      mask_d  = 8'd0;
      count_d = 3'd0;
    end else if (!bus.stall_in) begin
      case (state_q)
        IDLE: begin
          valid_d = 1'b0;
          if (accept) begin
            if (!isMultiOp(bus.in_op)) begin
              valid_d  = 1'b1;
              op_d     = bus.in_op;
              regA_d   = bus.in_regA;
              regB_d   = bus.in_regB;
              regC_d   = bus.in_regC;
              imm_d    = bus.in_imm;
              offset_d = 3'd0;
              first_d  = 1'b1;
              last_d   = 1'b1;
            end else if (inAny) begin
              valid_d  = 1'b1;
              op_d     = bus.in_op;
              regA_d   = bus.in_regA;
              regB_d   = inIdx;
              regC_d   = bus.in_regC;
              imm_d    = bus.in_imm;
              offset_d = 3'd0;
              first_d  = 1'b1;
              last_d   = (inRest == 8'd0);
              mask_d   = inRest;
              count_d  = 3'd1;
              state_d  = (inRest == 8'd0) ? IDLE : SEQ;
            end
          end
        end
        SEQ: begin
          if (pendAny) begin
            valid_d  = 1'b1;
            regB_d   = pendIdx;
            offset_d = count_q;
            first_d  = 1'b0;
            last_d   = (pendRest == 8'd0);
            mask_d   = pendRest;
            count_d  = (count_q == 3'd7) ? 3'd7 : count_q + 3'd1;
            if (pendRest == 8'd0) state_d = IDLE;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
        default: begin
          valid_d = 1'b0;
          state_d = IDLE;
          mask_d  = 8'd0;
          count_d = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      mask_q   <= 8'd0;
      count_q  <= 3'd0;
      valid_q  <= 1'b0;
      op_q     <= '0;
      regA_q   <= '0;
      regB_q   <= '0;
      regC_q   <= '0;
      imm_q    <= '0;
      offset_q <= 3'd0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      op_q     <= op_d;
      regA_q   <= regA_d;
      regB_q   <= regB_d;
      regC_q   <= regC_d;
      imm_q    <= imm_d;
      offset_q <= offset_d;
      first_q  <= first_d;
      last_q   <= last_d;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_op     = op_q;
  assign bus.out_regA   = regA_q;
  assign bus.out_regB   = regB_q;
  assign bus.out_regC   = regC_q;
  assign bus.out_imm    = imm_q;
  assign bus.out_offset = offset_q;
  assign bus.out_first  = first_q;
  assign bus.out_last   = last_q;

endmodule

// File: doc/lm_sm_sequencer.md
Name: lm_sm_sequencer

Overview:
- Decode-to-register-read pipeline register with a built-in LM/SM expander.
- Sits directly upstream of the register-read/EX stage and drives the `regread_ex_*` operand fields that the EX forwarding unit compares.
- Ordinary instructions pass through with one cycle of latency.
- LM and SM (multi-register load/store) are split into one micro-op per set bit of the 8-bit register mask. Each micro-op carries a target register index and an address offset. Upstream decode is held until the sequence finishes.

Parameters:
- `REGW`, 3, register index width
- `OPW`, 6, opcode field width; `[5:2]` is the major opcode, `[1:0]` the condition/function bits
- `IMMW`, 9, immediate width; LM/SM mask is `imm[7:0]`

Ports:
- `clk` in 1 — rising-edge clock
- `reset_n` in 1 — asynchronous, active-low reset
- `in_valid` in 1 — decode stage presents an instruction
- `in_op` in OPW — decoded opcode
- `in_regA` in REGW — regA field; base-address register for LM/SM
- `in_regB` in REGW — regB field
- `in_regC` in REGW — regC field
- `in_imm` in IMMW — immediate
- `stall_in` in 1 — downstream hazard stall; freeze this stage
- `flush` in 1 — branch/jump squash
- `in_ready` out 1 — decode may advance; equals `(state==IDLE) && !stall_in`
- `out_valid` out 1 — micro-op valid to register-read
- `out_op` out OPW
- `out_regA` out REGW — base register (LM/SM) or regA
- `out_regB` out REGW — LM/SM target register index; otherwise regB
- `out_regC` out REGW
- `out_imm` out IMMW
- `out_offset` out 3 — LM/SM address offset (0..7); 0 for all other ops
- `out_first` out 1 — first micro-op of an instruction
- `out_last` out 1 — last micro-op of an instruction

Behaviour:
- All outputs are registered.
- Reset (`reset_n` low, asynchronous):
  - state=IDLE, pending mask=0, count=0.
  - `out_valid`=0, all out fields=0, `out_first`=`out_last`=0.
  - `in_ready` follows its formula after reset.
- Multi-op detection: `in_op[5:2]`==4'b0110 (LM) or 4'b0111 (SM).
- Priority per rising edge: `flush` > `stall_in` > normal.
- Flush:
  - `out_valid`←0, state←IDLE, mask←0, count←0.
  - The input is not accepted, even if `in_valid` is high.
- Stall: every register, including state, mask and count, holds its value.
- IDLE, accept (`in_valid` && `in_ready`), single op:
  - out fields ← inputs, `out_valid`=1, `out_first`=`out_last`=1, `out_offset`=0.
  - Latency is 1 cycle.
- IDLE, accept, LM/SM with mask 0: `out_valid`←0 (bubble), stay in IDLE. Architecturally a no-op.
- IDLE, accept, LM/SM with nonzero mask:
  - Emit the micro-op for the lowest set bit `k`: `out_regB`=k, `out_offset`=0, `out_first`=1.
  - pending mask ← mask with bit `k` cleared; count←1.
  - If pending is 0: `out_last`=1, stay in IDLE.
  - Otherwise: `out_last`=0, go to SEQ.
  - `out_op`, `out_regA` and `out_imm` are latched from the instruction and held for the whole sequence.
- IDLE, no accept: `out_valid`←0.
- SEQ, not stalled, not flushed:
  - Emit the lowest set bit `j` of pending: `out_regB`=j, `out_offset`=count, `out_first`=0.
  - Clear bit `j`; count←count+1.
  - If the new pending mask is 0: `out_last`=1, state←IDLE.
- SEQ: `in_ready`=0, so decode holds the next instruction. There is no bubble between the last micro-op and the next accepted instruction.
- Width rules:
  - count saturates naturally at 7; it never wraps because at most 8 micro-ops are emitted.
  - Mask bits `imm[8]` are ignored.
- Reset asserted mid-sequence aborts it immediately. No partial state survives.
- `flush` and `stall_in` together: flush wins.

Decomposition:
- Shared package `isa_pkg`:
  - opcode constants ADD, NDU, ADC, ADZ, ADI, NDC, NDZ, LHI, LW, SW, LM, SM, BEQ, JAL, JLR (same encodings used by the forwarding unit);
  - REGW, OPW and IMMW localparams;
  - the state enum {IDLE, SEQ}.
- One sub-module, `pri_enc8`: 8-bit lowest-set-bit encoder. Outputs a 3-bit index and an `any` flag. Purely combinational; used for both the incoming mask and the pending mask.

Test Plan:
- Reset: hold `reset_n`=0 with random inputs. Expect `out_valid`=0 and all outputs 0. Release; `in_ready`=1 once `stall_in`=0.
- ADD pass-through: accept op 6'b000000, regA=1, regB=2, regC=3. One edge later: `out_valid`=1, fields equal, `first`=`last`=1, `offset`=0.
- LM expansion: accept op 6'b011000, regA=4, imm=9'h0A5. Expect 4 consecutive micro-ops with `regB`=0,2,5,7 and `offset`=0,1,2,3. `first` only on the first, `last` only on the fourth. `in_ready`=0 for the 3 middle cycles. A following ADD appears on the very next cycle.
- Stall/flush mid-sequence: during SM imm=9'h0FF, pulse `stall_in` for 2 cycles after the 3rd micro-op; outputs must hold, then resume with `regB`=3, `offset`=3. Then assert `flush` on the 5th micro-op: next cycle `out_valid`=0, `in_ready`=1.
- Mask edge cases: LM imm=0 gives `out_valid`=0 and IDLE. SM imm=9'h080 gives a single micro-op with `regB`=7, `offset`=0, `first`=`last`=1.
- Async reset mid-sequence: assert `reset_n`=0 between clock edges during an LM with imm=9'h0FF. Outputs clear immediately, without a clock edge. After release, a new ADD is accepted normally.
